// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler: shares one LFSR next-state datapath among R requesters.
// A round-robin arbiter grants one requester at a time. That requester's saved
// context is streamed out as a burst over a valid/ready port, and the advanced
// state is written back when the burst ends.
//
// Handshake: a word transfers on any clock edge where out_valid && out_ready.
// out_valid stays high until the word is taken, and out_data/out_id are held
// stable while out_ready is low.
//
// Optional feature macro: LFSR_WRAP_FLAG_EN (period-wrap flag on out_wrap).
module lfsr_rr_scheduler #(
  parameter int N     = 8,
  parameter int R     = 4,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [R-1:0]           req,
  input  logic [R*LEN_W-1:0]     req_len,
  input  logic                   seed_wr,
  input  logic [$clog2(R)-1:0]   seed_idx,
  input  logic [N-1:0]           seed_val,
  output logic [R-1:0]           gnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(R)-1:0]   out_id,
  output logic [R-1:0]           done,
  output logic                   busy,
  output logic                   out_wrap,
  output logic [1:0]             fsm_state
);

  localparam int IDW = $clog2(R);

  // Feedback tap masks; bit k set means state bit k feeds the XOR.
  localparam logic [7:0] TAPS = (N == 2) ? 8'h03 :
                                (N == 3) ? 8'h06 :
                                (N == 4) ? 8'h0C :
                                (N == 5) ? 8'h14 :
                                (N == 6) ? 8'h30 :
                                (N == 7) ? 8'h60 : 8'hB8;

  localparam logic [IDW:0] R_L = R;

  generate
    if (N < 2 || N > 8) begin : g_bad_n
      $error("lfsr_rr_scheduler: N must be in 2..8");
    end
    if (R < 2 || R > 8) begin : g_bad_r
      $error("lfsr_rr_scheduler: R must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GRANT, RUN, SAVE} state_t;

  state_t           state;
  logic [N-1:0]     ctx [R];
  logic [N-1:0]     work;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   pick;
  logic [LEN_W:0]   cnt;
  logic             seed_hit;
  logic [N-1:0]     seed_fix;

  // Shift left, feedback into bit 0.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return {s[N-2:0], ^(s & TAPS[N-1:0])};
  endfunction

  // First set request at or after the pointer, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [R-1:0] r,
                                             input logic [IDW-1:0] p);
    logic [IDW-1:0] sel;
    logic           found;
    int             j;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < R; i++) begin
      j = (int'(p) + i) % R;
      if (!found && r[j[IDW-1:0]]) begin
        found = 1'b1;
        sel   = j[IDW-1:0];
      end
    end
    return sel;
  endfunction

  assign pick      = rr_pick(req, rr_ptr);
  // Seed indices beyond R-1 (non power-of-two R) are dropped; zero seeds
  // would lock the LFSR, so they are stored as 1.
  assign seed_hit  = seed_wr && ({1'b0, seed_idx} < R_L);
  assign seed_fix  = (seed_val == '0) ? N'(1) : seed_val;
  assign out_data  = work;
  assign out_id    = id;
  assign fsm_state = state;

  // Arbitration / burst FSM with registered grant, valid, done and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      work      <= '0;
      id        <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            id    <= pick;
            gnt   <= R'(1) << pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          cnt       <= {1'b0, req_len[id*LEN_W +: LEN_W]} + 1'b1;
          work      <= ctx[id];
          out_valid <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (out_ready) begin
            work <= lfsr_step(work);
            cnt  <= cnt - 1'b1;
            if (cnt == (LEN_W+1)'(1)) begin
              out_valid <= 1'b0;
              done      <= R'(1) << id;
              state     <= SAVE;
            end
          end
        end
        SAVE: begin
          rr_ptr <= (id == IDW'(R - 1)) ? '0 : id + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Context store: burst writeback at the end of SAVE; a same-index seed
  // write in that cycle overrides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < R; i++) ctx[i] <= N'(1);
    end else begin
      if (state == SAVE) ctx[id] <= work;
      if (seed_hit) ctx[seed_idx] <= seed_fix;
    end
  end

`ifdef LFSR_WRAP_FLAG_EN
  logic [N-1:0] seed_copy [R];
  logic [R-1:0] fresh;

  // Last seed per context, plus a flag meaning no word has been emitted
  // from that context since the seed was written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < R; i++) seed_copy[i] <= N'(1);
      fresh <= '1;
    end else begin
      if (state == RUN && out_ready) fresh[id] <= 1'b0;
      if (seed_hit) begin
        seed_copy[seed_idx] <= seed_fix;
        fresh[seed_idx]     <= 1'b1;
      end
    end
  end

  assign out_wrap = out_valid && (work == seed_copy[id]) && !fresh[id];
`else
  assign out_wrap = 1'b0;
`endif

endmodule
